apb_master: RTL and testbench
=============================

Name: apb_master

Overview:
- Single-outstanding APB initiator that turns a valid/ready request channel into APB SETUP/ACCESS transfers.
- Returns read data and error status on a valid/ready response channel.
- Sits upstream of top_apb_demux and drives its psel_i/paddr_i/pwrite_i/penable_i/pwdata_i; consumes prdata_o/pready_o/pslverr_o, including the demux decode-error response.

Parameters:
- APB_ADDR_WIDTH, 32, address width.
- APB_DATA_WIDTH, 32, data width.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles before abort; legal range >= 1; used only with APB_MASTER_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock, all logic rising-edge.
- rst_i  in  1  asynchronous reset, active-high.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid&&ready.
- req_addr_i  in  APB_ADDR_WIDTH  transfer address.
- req_write_i  in  1  1=write, 0=read.
- req_wdata_i  in  APB_DATA_WIDTH  write data.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed when valid&&ready.
- rsp_rdata_o  out  APB_DATA_WIDTH  read data; 0 for writes and errors.
- rsp_err_o  out  1  slave error or timeout.
- psel_o  out  1  APB select.
- paddr_o  out  APB_ADDR_WIDTH  APB address.
- pwrite_o  out  1  APB direction.
- penable_o  out  1  APB enable.
- pwdata_o  out  APB_DATA_WIDTH  APB write data.
- prdata_i  in  APB_DATA_WIDTH  APB read data.
- pready_i  in  1  APB ready.
- pslverr_i  in  1  APB slave error.

Behaviour:
- FSM states: IDLE, SETUP, ACCESS, RESP. All APB and rsp outputs are registered or decoded directly from the state register; no combinational path from inputs to outputs.
- Reset, asynchronous and immediate:
  - state=IDLE; psel_o=0, penable_o=0.
  - paddr_o, pwdata_o, pwrite_o, rsp_rdata_o = 0; rsp_err_o=0, rsp_valid_o=0.
  - req_ready_o=1, since it equals (state==IDLE).
- Reset mid-transfer drops psel/penable in the same cycle; the transfer is discarded and no response is produced.
- IDLE: on req_valid_i&&req_ready_o, latch addr/write/wdata into paddr_o/pwrite_o/pwdata_o, then go to SETUP.
- SETUP: psel_o=1, penable_o=0, exactly one cycle, then ACCESS.
- ACCESS: psel_o=1, penable_o=1.
  - On pready_i=1: capture rsp_err_o=pslverr_i and rsp_rdata_o = (read && !pslverr_i) ? prdata_i : 0, then go to RESP.
  - On pready_i=0: stay in ACCESS, subject to timeout.
- RESP: psel_o=0, penable_o=0, rsp_valid_o=1. rsp_rdata_o/rsp_err_o hold stable until rsp_ready_i=1, then go to IDLE.
- paddr_o/pwrite_o/pwdata_o are stable from SETUP through the end of ACCESS and hold their last value afterwards.
- Latency: request accepted at cycle 0 → SETUP at cycle 1 → ACCESS at cycle 2. With pready_i=1 at cycle 2, rsp_valid_o=1 at cycle 3. Minimum 4 cycles per transaction when rsp_ready_i is held high.
- Only one transaction is outstanding; req_ready_o=0 in SETUP/ACCESS/RESP.
- Requests presented outside IDLE are ignored; the requester must hold them.

Optional Feature:
- Macro APB_MASTER_TIMEOUT_EN.
- Defined:
  - Counter width $clog2(TIMEOUT_CYCLES+1); cleared on entry to ACCESS; increments each ACCESS cycle with pready_i=0.
  - If the counter == TIMEOUT_CYCLES-1 and pready_i=0, abort: go to RESP with rsp_err_o=1 and rsp_rdata_o=0. ACCESS therefore lasts at most TIMEOUT_CYCLES cycles.
  - pready_i=1 in the final cycle wins over timeout.
- Not defined: no counter; ACCESS waits indefinitely for pready_i.

Decomposition:
- Package apb_pkg contents:
  - apb_master_state_e enum (IDLE, SETUP, ACCESS, RESP).
  - apb_req_t struct (addr, write, wdata).
  - apb_rsp_t struct (rdata, err).
  - Widths are passed as parameters; the package holds only defaults.
- Sub-module apb_master_timeout: the counter and expiry flag, instantiated under APB_MASTER_TIMEOUT_EN.

Test Plan:
- Write 0x1000_0004 / 0xDEAD_BEEF, pready_i=1 immediately → psel_o rises cycle 1, penable_o rises cycle 2, paddr/pwdata stable both cycles; rsp_valid_o cycle 3 with err=0, rdata=0.
- Read 0x2000_0000, pready_i low 3 ACCESS cycles then high with prdata_i=0x1234_5678 → ACCESS lasts 4 cycles; rsp_rdata_o=0x1234_5678, err=0.
- Read from an unmapped address via top_apb_demux (pready=1, pslverr=1) → rsp_err_o=1, rsp_rdata_o=0.
- Timeout enabled, TIMEOUT_CYCLES=4, pready_i stuck 0 → exactly 4 ACCESS cycles, then RESP with err=1.
- Same setup, pready_i=1 in 4th ACCESS cycle → err=0, data captured.
- rsp_ready_i held 0 for 5 cycles, then rst_i pulsed during a later ACCESS → response held stable, req_ready_o=0 throughout the hold; psel_o/penable_o drop asynchronously on reset and no response is issued.

Source files
------------

// File: rtl/apb_pkg.sv
// apb_pkg: shared FSM state, request/response types and default widths for apb_master.
package apb_pkg;
    localparam int APB_ADDR_WIDTH_DEF = 32;
    localparam int APB_DATA_WIDTH_DEF = 32;
    localparam int TIMEOUT_CYCLES_DEF = 16;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_master_state_e;

    typedef struct packed {
        logic [APB_ADDR_WIDTH_DEF-1:0] addr;
        logic                          write;
        logic [APB_DATA_WIDTH_DEF-1:0] wdata;
    } apb_req_t;

    typedef struct packed {
        logic [APB_DATA_WIDTH_DEF-1:0] rdata;
        logic                          err;
    } apb_rsp_t;
endpackage

// File: rtl/apb_master_timeout.sv
// apb_master_timeout: counts stalled ACCESS cycles and flags the last one allowed
// (used by apb_master only when APB_MASTER_TIMEOUT_EN is defined).
module apb_master_timeout #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear,
    input  logic step,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (step)
            cnt <= cnt + 1'b1;
    end

    assign expired = step && cnt == CW'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/apb_master.sv
// apb_master: single-outstanding APB initiator bridging a valid/ready request/response pair.
// Optional ACCESS timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master
    import apb_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = APB_ADDR_WIDTH_DEF,
    parameter int APB_DATA_WIDTH = APB_DATA_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
    input  logic                      req_write_i,
    input  logic [APB_DATA_WIDTH-1:0] req_wdata_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [APB_DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic                      psel_o,
    output logic [APB_ADDR_WIDTH-1:0] paddr_o,
    output logic                      pwrite_o,
    output logic                      penable_o,
    output logic [APB_DATA_WIDTH-1:0] pwdata_o,
    input  logic [APB_DATA_WIDTH-1:0] prdata_i,
    input  logic                      pready_i,
    input  logic                      pslverr_i
);
    apb_master_state_e state;
    logic              timeout;

`ifdef APB_MASTER_TIMEOUT_EN
    apb_master_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear   (state == SETUP),
        .step    (state == ACCESS && !pready_i),
        .expired (timeout)
    );
`else
    // Without the timeout feature ACCESS never aborts for any legal TIMEOUT_CYCLES.
    assign timeout = TIMEOUT_CYCLES < 1;
`endif

    // Handshake and APB strobes decode straight from the state register.
    assign req_ready_o = state == IDLE;
    assign psel_o      = state == SETUP || state == ACCESS;
    assign penable_o   = state == ACCESS;
    assign rsp_valid_o = state == RESP;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            paddr_o     <= '0;
            pwrite_o    <= 1'b0;
            pwdata_o    <= '0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid_i) begin
                    paddr_o  <= req_addr_i;
                    pwrite_o <= req_write_i;
                    pwdata_o <= req_wdata_i;
                    state    <= SETUP;
                end
                SETUP: state <= ACCESS;
                ACCESS: if (pready_i) begin
                    rsp_err_o   <= pslverr_i;
                    rsp_rdata_o <= (!pwrite_o && !pslverr_i) ? prdata_i : '0;
                    state       <= RESP;
                end else if (timeout) begin
                    rsp_err_o   <= 1'b1;
                    rsp_rdata_o <= '0;
                    state       <= RESP;
                end
                RESP: if (rsp_ready_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: randomized APB transactions checked against a transaction-level model of apb_master.
module tb_apb_master;
    import apb_pkg::*;

    localparam int T = 4;

    logic        clk = 0, rst = 1;
    logic        req_valid = 0, req_ready, req_write = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic        rsp_valid, rsp_ready = 0, rsp_err;
    logic [31:0] rsp_rdata;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [31:0] prdata = 0;
    logic        pready = 0, pslverr = 0;

    int total = 0, bad = 0;

    apb_master #(.APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32), .TIMEOUT_CYCLES(T)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
        .req_write_i(req_write), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .psel_o(psel), .paddr_o(paddr), .pwrite_o(pwrite), .penable_o(penable), .pwdata_o(pwdata),
        .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full transaction: the model says how long ACCESS lasts and what the response is.
    task automatic run(apb_req_t rq, int waits, logic err, logic [31:0] rd, int hold);
        apb_rsp_t exp;
        int       exp_n, n;
        bit       to;
`ifdef APB_MASTER_TIMEOUT_EN
        to = waits >= T;
`else
        to = 0;
`endif
        exp_n     = to ? T : waits + 1;
        exp.err   = to || err;
        exp.rdata = (!rq.write && !exp.err) ? rd : 32'h0;
        @(negedge clk);
        check("idle_ready", req_ready, 1);
        req_valid = 1; req_addr = rq.addr; req_write = rq.write; req_wdata = rq.wdata;
        @(negedge clk);
        req_valid = 0; req_addr = $urandom; req_write = 1'($urandom); req_wdata = $urandom;
        check("setup_strobes", {psel, penable}, 2'b10);
        check("setup_addr", {pwrite, paddr}, {rq.write, rq.addr});
        check("setup_wdata", pwdata, rq.wdata);
        check("setup_ready", req_ready, 0);
        @(negedge clk);
        n = 0;
        while (psel && penable && n < 64) begin
            check("access_addr", {pwrite, paddr}, {rq.write, rq.addr});
            check("access_wdata", pwdata, rq.wdata);
            pready  = (n == waits);
            pslverr = (n == waits) ? err : 1'($urandom);
            prdata  = (n == waits) ? rd : $urandom;
            n++;
            @(negedge clk);
            pready = 0;
        end
        check("access_len", n, exp_n);
        for (int i = 0; i <= hold; i++) begin
            check("rsp_valid", rsp_valid, 1);
            check("rsp_err", rsp_err, exp.err);
            check("rsp_rdata", rsp_rdata, exp.rdata);
            check("rsp_strobes", {psel, penable}, 2'b00);
            check("rsp_busy", req_ready, 0);
            if (i < hold) begin
                req_valid = 1; req_addr = $urandom; req_wdata = $urandom;
                @(negedge clk);
            end
        end
        req_valid = 0;
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        check("rsp_done", rsp_valid, 0);
        check("back_idle", req_ready, 1);
        check("addr_hold", paddr, rq.addr);
    endtask

    task automatic reset_mid_access();
        @(negedge clk);
        req_valid = 1; req_addr = 32'h3000_0010; req_write = 0;
        @(negedge clk);
        req_valid = 0;
        repeat (2) @(negedge clk);
        check("pre_rst_access", {psel, penable}, 2'b11);
        #2 rst = 1;
        #1;
        check("rst_async_strobes", {psel, penable}, 2'b00);
        check("rst_async_ready", req_ready, 1);
        @(negedge clk);
        rst = 0;
        repeat (3) begin
            @(negedge clk);
            check("rst_no_rsp", rsp_valid, 0);
        end
        check("rst_addr", paddr, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        apb_req_t rq;
        #12;
        check("reset_strobes", {psel, penable, rsp_valid, rsp_err}, 4'b0000);
        check("reset_ready", req_ready, 1);
        check("reset_regs", {paddr, pwdata}, 64'h0);
        check("reset_rdata", {pwrite, rsp_rdata}, 33'h0);
        @(negedge clk);
        rst = 0;
        run('{addr: 32'h1000_0004, write: 1, wdata: 32'hDEAD_BEEF}, 0, 0, 32'hFFFF_FFFF, 0);
        run('{addr: 32'h2000_0000, write: 0, wdata: 32'h0}, 3, 0, 32'h1234_5678, 0);
        run('{addr: 32'hF000_0000, write: 0, wdata: 32'h0}, 0, 1, 32'hAAAA_5555, 0);
        run('{addr: 32'h2000_0008, write: 0, wdata: 32'h0}, 10, 0, 32'h0BAD_F00D, 0);
        run('{addr: 32'h2000_000C, write: 0, wdata: 32'h0}, T - 1, 0, 32'hCAFE_0001, 0);
        run('{addr: 32'h4000_0000, write: 1, wdata: 32'h5555_AAAA}, 1, 0, 32'h0, 5);
        reset_mid_access();
        for (int k = 0; k < 40; k++) begin
            rq.addr  = $urandom;
            rq.write = 1'($urandom);
            rq.wdata = $urandom;
            run(rq, $urandom_range(0, 6), 1'($urandom_range(0, 3) == 0), $urandom, $urandom_range(0, 3));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
